// File: rtl/tug_match_ctrl.sv
// Tug-of-war match sequencer: countdown, press gating, round scoring, hold and match-over.
// Optional false-start handling during the countdown is enabled by defining TUG_FALSE_START_EN.
module tug_match_ctrl #(
  parameter int WIN_ROUNDS  = 3,
  parameter int CD_DIGITS   = 3,
  parameter int TICK_CYCLES = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       left_press,
  input  logic       right_press,
  input  logic       left_end,
  input  logic       right_end,
  output logic       l_out,
  output logic       r_out,
  output logic       round_reset,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [3:0] countdown,
  output logic       match_over,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CNTDN = 3'd1,
    S_PLAY  = 3'd2,
    S_HOLD  = 3'd3,
    S_OVER  = 3'd4
  } st_t;

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [3:0]    WIN       = 4'(WIN_ROUNDS);
  localparam logic [3:0]    CD        = 4'(CD_DIGITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  st_t           st;
  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt;

  assign state = st;
  // Presses reach the light chain with no latency; a simultaneous pair cancels.
  assign l_out = (st == S_PLAY) & left_press & ~right_press;
  assign r_out = (st == S_PLAY) & right_press & ~left_press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_IDLE;
      score_l     <= 4'd0;
      score_r     <= 4'd0;
      countdown   <= 4'd0;
      winner      <= 2'b00;
      match_over  <= 1'b0;
      round_reset <= 1'b0;
      tick_cnt    <= '0;
      hold_cnt    <= '0;
    end else begin
      round_reset <= 1'b0;
      case (st)
        S_IDLE, S_OVER: begin
          if (start) begin
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            winner      <= 2'b00;
            match_over  <= 1'b0;
            countdown   <= CD;
            tick_cnt    <= '0;
            round_reset <= 1'b1;
            st          <= S_CNTDN;
          end
        end
        S_CNTDN: begin
`ifdef TUG_FALSE_START_EN
          if (left_press && right_press) begin
            countdown <= CD;
            tick_cnt  <= '0;
          end else if (left_press || right_press) begin
            // The player who jumped the gun forfeits the round.
            if (left_press) begin
              if (score_r < WIN) score_r <= score_r + 4'd1;
            end else begin
              if (score_l < WIN) score_l <= score_l + 4'd1;
            end
            countdown <= 4'd0;
            hold_cnt  <= '0;
            st        <= S_HOLD;
          end else
`endif
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (countdown <= 4'd1) begin
              countdown <= 4'd0;
              st        <= S_PLAY;
            end else begin
              countdown <= countdown - 4'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_PLAY: begin
          if (left_end || right_end) begin
            // Both ends in one cycle is a draw: no score change.
            if (left_end && !right_end && score_l < WIN) score_l <= score_l + 4'd1;
            if (right_end && !left_end && score_r < WIN) score_r <= score_r + 4'd1;
            hold_cnt <= '0;
            st       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            if (score_l == WIN || score_r == WIN) begin
              st         <= S_OVER;
              match_over <= 1'b1;
              winner     <= (score_l == WIN) ? 2'b01 : 2'b10;
            end else begin
              round_reset <= 1'b1;
              countdown   <= CD;
              tick_cnt    <= '0;
              st          <= S_CNTDN;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
